// File: rtl/led_pattern_sequencer.sv
// Green-LED pattern sequencer for the DE2 board: debounces the mode/speed keys,
// divides CLOCK_50 into pattern ticks and steps OFF/BLINK/CHASE/BOUNCE on LEDG.
module led_pattern_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BASE_TICKS      = 6_250_000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic [7:0] LEDG,
  output logic [4:0] LEDR
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CW = $clog2(8 * BASE_TICKS);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  logic w_rst_n;
  assign w_rst_n = KEY[0];

  // ---------------------------------------------------------------------------
  // Key front end: bit k of these vectors serves KEY[k+1]
  // ---------------------------------------------------------------------------
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db;
  logic [2:0]    r_db_d;
  logic [2:0]    r_press;
  logic [DW-1:0] r_db_cnt [3];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= KEY[3:1];
      r_sync2 <= r_sync1;
    end
  end

  // Press pulse comes from a delayed copy of the debounced level, so it lands
  // one edge after the debounced level falls.
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_db    <= 3'b111;
      r_db_d  <= 3'b111;
      r_press <= 3'b000;
      // NOTE: the counter array is tiny and must restart from zero on reset,
      // so each element is cleared explicitly rather than left to power-up.
      for (int k = 0; k < 3; k++) begin
        r_db_cnt[k] <= '0;
      end
    end else begin
      r_db_d  <= r_db;
      r_press <= r_db_d & ~r_db;
      for (int k = 0; k < 3; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_db[k]     <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DW'(1);
        end
      end
    end
  end

  logic w_mode_ev;
  logic w_up_ev;
  logic w_dn_ev;
  assign w_mode_ev = r_press[0];
  assign w_up_ev   = r_press[1];
  assign w_dn_ev   = r_press[2];

  // ---------------------------------------------------------------------------
  // Mode state machine and speed register
  // ---------------------------------------------------------------------------
  mode_e      r_mode;
  mode_e      w_mode_next;
  logic [2:0] r_speed;
  logic [2:0] w_speed_next;
  logic       w_speed_chg;

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_mode  <= MODE_OFF;
      r_speed <= 3'd0;
    end else begin
      r_mode  <= w_mode_next;
      r_speed <= w_speed_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_mode_next = r_mode;
    if (w_mode_ev) begin
      case (r_mode)
        MODE_OFF:    w_mode_next = MODE_BLINK;
        MODE_BLINK:  w_mode_next = MODE_CHASE;
        MODE_CHASE:  w_mode_next = MODE_BOUNCE;
        MODE_BOUNCE: w_mode_next = MODE_OFF;
        default:     w_mode_next = MODE_OFF;
      endcase
    end
  end

  // Opposing events in one cycle cancel; saturated requests are not changes.
  always_comb begin
    w_speed_next = r_speed;
    w_speed_chg  = 1'b0;
    if (w_up_ev && !w_dn_ev && (r_speed != 3'd7)) begin
      w_speed_next = r_speed + 3'd1;
      w_speed_chg  = 1'b1;
    end else if (w_dn_ev && !w_up_ev && (r_speed != 3'd0)) begin
      w_speed_next = r_speed - 3'd1;
      w_speed_chg  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick generator: period = BASE_TICKS * (8 - speed)
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_tick_cnt;
  logic [CW-1:0] w_period_m1;
  logic          w_tick;
  logic          w_cnt_clear;

  assign w_period_m1 = CW'(BASE_TICKS * (8 - int'(r_speed)) - 1);
  assign w_tick      = (r_tick_cnt == w_period_m1);
  assign w_cnt_clear = w_mode_ev || w_speed_chg || w_tick;

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_cnt_clear) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern state: mode entry overrides any tick landing on the same edge
  // ---------------------------------------------------------------------------
  logic [7:0] r_pattern;
  logic [7:0] w_pattern_next;
  logic       r_dir_right;
  logic       w_dir_right_next;

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pattern   <= 8'h00;
      r_dir_right <= 1'b0;
    end else begin
      r_pattern   <= w_pattern_next;
      r_dir_right <= w_dir_right_next;
    end
  end

  always_comb begin
    w_pattern_next   = r_pattern;
    w_dir_right_next = r_dir_right;
    if (w_mode_ev) begin
      w_dir_right_next = 1'b0;
      case (w_mode_next)
        MODE_OFF:    w_pattern_next = 8'h00;
        MODE_BLINK:  w_pattern_next = 8'hFF;
        MODE_CHASE:  w_pattern_next = 8'h01;
        MODE_BOUNCE: w_pattern_next = 8'h01;
        default:     w_pattern_next = 8'h00;
      endcase
    end else if (w_tick) begin
      case (r_mode)
        MODE_BLINK: w_pattern_next = ~r_pattern;
        MODE_CHASE: w_pattern_next = {r_pattern[6:0], r_pattern[7]};
        MODE_BOUNCE: begin
          if (!r_dir_right) begin
            w_pattern_next = {r_pattern[6:0], 1'b0};
            if (w_pattern_next == 8'h80) w_dir_right_next = 1'b1;
          end else begin
            w_pattern_next = {1'b0, r_pattern[7:1]};
            if (w_pattern_next == 8'h01) w_dir_right_next = 1'b0;
          end
        end
        default: w_pattern_next = r_pattern;
      endcase
    end
  end

  assign LEDG = r_pattern;
  assign LEDR = {r_speed, r_mode};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed steps plus random key traffic, with
// every cycle compared against a pattern-phase model of the LED behaviour.
module tb_led_pattern_sequencer;

  localparam int D = 4;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic [3:0] key;
  logic [7:0] ledg;
  logic [4:0] ledr;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.DEBOUNCE_CYCLES(D), .BASE_TICKS(B)) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .LEDG    (ledg),
    .LEDR    (ledr)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode/speed values, ticks since mode entry, cycles since last clear,
  // and per key the last D+2 raw samples with the accepted level.
  int m_mode, m_speed, m_phase, m_cnt, edge_no;
  bit m_db [3];
  int m_apply [3];
  bit m_hist [3][D+2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_pattern();
    int pos;
    case (m_mode)
      1: return (m_phase % 2 == 1) ? 8'h00 : 8'hFF;
      2: return 8'h01 << (m_phase % 8);
      3: begin
        pos = m_phase % 14;
        if (pos > 7) pos = 14 - pos;
        return 8'h01 << pos;
      end
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [4:0] m_ledr();
    return {m_speed[2:0], m_mode[1:0]};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_speed = 0; m_phase = 0; m_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      m_db[k] = 1'b1;
      m_apply[k] = -1;
      for (int j = 0; j < D + 2; j++) m_hist[k][j] = 1'b1;
    end
  endtask

  // A key level is accepted once D consecutive synchronized samples (raw
  // samples delayed two edges) disagree with it; a press acts two edges later.
  task automatic model_edge(input logic [2:0] ks);
    int  period, new_speed;
    bit  tick, mode_ev, up, dn, spd_chg, all_diff;
    edge_no++;
    period  = B * (8 - m_speed);
    tick    = (m_cnt == period - 1);
    mode_ev = (m_apply[0] == edge_no);
    up      = (m_apply[1] == edge_no);
    dn      = (m_apply[2] == edge_no);
    new_speed = m_speed;
    if (up && !dn && m_speed < 7) new_speed = m_speed + 1;
    else if (dn && !up && m_speed > 0) new_speed = m_speed - 1;
    spd_chg = (new_speed != m_speed);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < D + 1; j++) m_hist[k][j] = m_hist[k][j+1];
      m_hist[k][D+1] = ks[k];
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (m_hist[k][j] == m_db[k]) all_diff = 1'b0;
      if (all_diff) begin
        m_db[k] = ~m_db[k];
        if (!m_db[k]) m_apply[k] = edge_no + 2;
      end
    end
    if (mode_ev) begin
      m_mode  = (m_mode + 1) % 4;
      m_phase = 0;
    end else if (tick) begin
      m_phase++;
    end
    if (mode_ev || spd_chg || tick) m_cnt = 0;
    else m_cnt++;
    m_speed = new_speed;
  endtask

  task automatic step();
    @(posedge clk);
    if (key[0]) model_edge(key[3:1]);
    #1;
    check("ledg", ledg, m_pattern());
    check("ledr", ledr, m_ledr());
  endtask

  task automatic press(input int k);
    key[k] = 1'b0;
    repeat (D + 4) step();
    key[k] = 1'b1;
    repeat (D + 4) step();
  endtask

  task automatic async_reset();
    #3 key[0] = 1'b0;
    #1;
    check("async_ledg", ledg, 8'h00);
    check("async_ledr", ledr, 5'd0);
    model_reset();
  endtask

  initial begin
    logic [7:0] snap, inv;
    int sel, hold, gap;
    edge_no = 0;
    key = 4'b1110;
    model_reset();
    repeat (3) step();
    check("rst_ledg", ledg, 8'h00);
    check("rst_ledr", ledr, 5'd0);
    key[0] = 1'b1;
    repeat (100) step();
    check("idle_ledr", ledr, 5'd0);

    // Short glitch on KEY[1] is filtered.
    key[1] = 1'b0;
    repeat (3) step();
    key[1] = 1'b1;
    repeat (12) step();
    check("glitch_ledr", ledr, 5'd0);

    // Held press: mode changes at edge N+7, blink toggles 16 cycles later.
    key[1] = 1'b0;
    repeat (7) step();
    check("press_before", ledr, 5'd0);
    step();
    check("press_mode", ledr, 5'd1);
    check("blink_entry", ledg, 8'hFF);
    repeat (15) step();
    check("blink_hold", ledg, 8'hFF);
    step();
    check("blink_toggle", ledg, 8'h00);
    repeat (20) step();
    check("hold_one_event", ledr, 5'd1);
    key[1] = 1'b1;
    repeat (D + 4) step();

    // BOUNCE sweep, then wrap back to OFF.
    press(1);
    press(1);
    check("mode_bounce", ledr, 5'd3);
    repeat (16 * 16) step();
    press(1);
    check("mode_off", ledr, 5'd0);
    check("off_ledg", ledg, 8'h00);

    // CHASE with speed saturation and cancelled opposing events.
    press(1);
    press(1);
    repeat (9) press(2);
    check("speed_sat", ledr, {3'd7, 2'd2});
    repeat (20) step();
    key[2] = 1'b0;
    key[3] = 1'b0;
    repeat (D + 4) step();
    key[2] = 1'b1;
    key[3] = 1'b1;
    repeat (D + 4) step();
    check("speed_cancel", ledr, {3'd7, 2'd2});

    // BLINK at speed 0, speed-up mid-period restarts the period at 14.
    press(1);
    press(1);
    press(1);
    repeat (7) press(3);
    check("blink_slow", ledr, {3'd0, 2'd1});
    repeat (21) step();
    key[2] = 1'b0;
    repeat (8) step();
    check("speed_up", ledr, {3'd1, 2'd1});
    snap = m_pattern();
    inv  = ~snap;
    repeat (13) step();
    check("no_early_toggle", ledg, snap);
    step();
    check("toggle_at_14", ledg, inv);
    key[2] = 1'b1;
    repeat (D + 4) step();

    // Reset mid-BOUNCE while KEY[1] is mid-debounce.
    press(1);
    press(1);
    repeat (37) step();
    key[1] = 1'b0;
    repeat (2) step();
    async_reset();
    key[1] = 1'b1;
    repeat (4) step();
    key[0] = 1'b1;
    repeat (40) step();
    check("no_spurious", ledr, 5'd0);

    // Random key traffic with occasional resets.
    repeat (300) begin
      sel  = $urandom_range(1, 7);
      hold = $urandom_range(1, 12);
      gap  = $urandom_range(1, 12);
      key[3:1] = ~sel[2:0];
      repeat (hold) step();
      key[3:1] = 3'b111;
      repeat (gap) step();
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
        repeat (2) step();
        key[0] = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
